// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Imported by the unit and its helper blocks.
package muldiv_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negate, used for operand
// magnitudes and result sign correction.
module cond_negate #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// One radix-2 step per cycle on magnitudes, sign fixed at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] hi_wdata,
   input  logic [WIDTH-1:0] lo_wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] bm_q, bm_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             div_q, div_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dzo_q, dzo_d;

   logic             st_signed;
   logic             st_div;
   logic             st_sa;
   logic             st_sb;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign st_signed = (op == OP_MULT) || (op == OP_DIV);
   assign st_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign st_sa     = st_signed & a[WIDTH-1];
   assign st_sb     = st_signed & b[WIDTH-1];

   cond_negate #(.WIDTH(WIDTH)) u_mag_a (
      .neg  (st_sa),
      .din  (a),
      .dout (a_mag)
   );

   cond_negate #(.WIDTH(WIDTH)) u_mag_b (
      .neg  (st_sb),
      .din  (b),
      .dout (b_mag)
   );

   // multiply: {acc,quo} shifts right, multiplier bits leave quo[0]
   logic [WIDTH:0]   mul_sum;
   assign mul_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, bm_q} : '0);

   // restoring divide: {acc,quo} shifts left, quotient bits enter quo[0]
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   assign rem_sh = {acc_q, quo_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, bm_q};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
      .neg  (sa_q ^ sb_q),
      .din  ({acc_q, quo_q}),
      .dout (prod_fix)
   );

   cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
      .neg  ((sa_q ^ sb_q) & ~dz_q),
      .din  (quo_q),
      .dout (quo_fix)
   );

   cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
      .neg  (sa_q),
      .din  (acc_q),
      .dout (rem_fix)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      quo_d   = quo_q;
      bm_d    = bm_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      div_d   = div_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dzo_d   = dzo_q;
      unique case (state_q)
         S_IDLE: begin
            if (mthi) hi_d = hi_wdata;
            if (mtlo) lo_d = lo_wdata;
            if (start && !flush) begin
               state_d = S_RUN;
               cnt_d   = '0;
               acc_d   = '0;
               quo_d   = a_mag;
               bm_d    = b_mag;
               sa_d    = st_sa;
               sb_d    = st_sb;
               div_d   = st_div;
               dz_d    = st_div && (b == '0);
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (div_q) begin
                  if (!trial[WIDTH]) begin
                     acc_d = trial[WIDTH-1:0];
                     quo_d = {quo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_d = rem_sh[WIDTH-1:0];
                     quo_d = {quo_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_d = mul_sum[WIDTH:1];
                  quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               dzo_d  = dz_q;
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = dz_q ? '1 : quo_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         quo_q   <= '0;
         bm_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dzo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         bm_q    <= bm_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         div_q   <= div_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dzo_q   <= dzo_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign div_by_zero = dzo_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         flush;
   logic         mthi, mtlo;
   logic [W-1:0] hi_wdata, lo_wdata;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int           total = 0;
   int           bad = 0;
   int unsigned  cyc = 0;
   logic [W-1:0] mhi = '0;
   logic [W-1:0] mlo = '0;
   logic         mdz = 1'b0;

   muldiv_unit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .flush       (flush),
      .mthi        (mthi),
      .mtlo        (mtlo),
      .hi_wdata    (hi_wdata),
      .lo_wdata    (lo_wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void ref_op(input logic [1:0] o,
                                  input logic [W-1:0] x, y,
                                  output logic [W-1:0] h, l,
                                  output logic z);
      longint          sx, sy, p, q, r;
      longint unsigned up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      z  = 1'b0;
      case (o)
         OP_MULT: begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
         end
         OP_MULTU: begin
            up = {32'd0, x} * {32'd0, y};
            h  = up[63:32];
            l  = up[31:0];
         end
         OP_DIV: begin
            if (y == 0) begin
               z = 1'b1; h = x; l = '1;
            end else begin
               q = sx / sy;
               r = sx % sy;
               h = r[31:0];
               l = q[31:0];
            end
         end
         default: begin
            if (y == 0) begin
               z = 1'b1; h = x; l = '1;
            end else begin
               h = x % y;
               l = x / y;
            end
         end
      endcase
   endfunction

   task automatic launch(input logic [1:0] o, input logic [W-1:0] x, y,
                         output int unsigned t0);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic finish_op(input int unsigned t0, input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 64'(cyc - t0), 64'(33));
      chk({tag, "_busy0"}, 64'(busy), 64'(0));
      chk({tag, "_hi"}, 64'(hi), 64'(mhi));
      chk({tag, "_lo"}, 64'(lo), 64'(mlo));
      chk({tag, "_dz"}, 64'(div_by_zero), 64'(mdz));
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(done), 64'(0));
      chk({tag, "_dzhold"}, 64'(div_by_zero), 64'(mdz));
   endtask

   task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, y,
                        input string tag);
      int unsigned t0;
      ref_op(o, x, y, mhi, mlo, mdz);
      launch(o, x, y, t0);
      chk({tag, "_busy1"}, 64'(busy), 64'(1));
      finish_op(t0, tag);
   endtask

   initial begin
      int unsigned  t0;
      int           nd;
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      logic [W-1:0] eh, el;
      logic         ez;

      rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      hi_wdata = '0; lo_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_dz", 64'(div_by_zero), 64'(0));
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));

      do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      chk("multu_max_hi_c", 64'(hi), 64'hFFFF_FFFE);
      do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg");
      chk("mult_neg_lo_c", 64'(lo), 64'hFFFF_FFF1);
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
      chk("div_neg_lo_c", 64'(lo), 64'hFFFF_FFFD);
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      chk("div_ovf_lo_c", 64'(lo), 64'h8000_0000);
      do_op(OP_DIVU, 32'd100, 32'd0, "divu_z");
      chk("divu_z_dz_c", 64'(div_by_zero), 64'(1));
      do_op(OP_DIV, 32'hFFFF_FF00, 32'd0, "div_z");

      // MTHI in idle, then a second start and MT mid-run are ignored
      mthi = 1'b1; hi_wdata = 32'h1234;
      @(negedge clk);
      mthi = 1'b0;
      mhi = 32'h1234;
      chk("mthi_idle", 64'(hi), 64'h1234);
      ref_op(OP_DIVU, 32'd9, 32'd4, eh, el, ez);
      launch(OP_DIVU, 32'd9, 32'd4, t0);
      repeat (4) @(negedge clk);
      start = 1'b1; op = OP_MULTU; a = '1; b = '1;
      mthi = 1'b1; mtlo = 1'b1; hi_wdata = 32'hDEAD; lo_wdata = 32'hBEEF;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      chk("busy_mthi", 64'(hi), 64'h1234);
      chk("busy_mtlo", 64'(lo), 64'(mlo));
      mhi = eh; mlo = el; mdz = ez;
      finish_op(t0, "restart");
      chk("restart_hi_c", 64'(hi), 64'(1));
      chk("restart_lo_c", 64'(lo), 64'(2));

      // MT writes land with start, result overwrites them later
      mthi = 1'b1; mtlo = 1'b1; hi_wdata = 32'hABC; lo_wdata = 32'h55;
      ref_op(OP_MULT, 32'd7, 32'hFFFF_FFFE, eh, el, ez);
      launch(OP_MULT, 32'd7, 32'hFFFF_FFFE, t0);
      mthi = 1'b0; mtlo = 1'b0;
      chk("mt_start_hi", 64'(hi), 64'hABC);
      chk("mt_start_lo", 64'(lo), 64'h55);
      mhi = eh; mlo = el; mdz = ez;
      finish_op(t0, "mt_start");

      // start together with flush in idle is dropped
      start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd5; b = 32'd1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("sf_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("sf_done", 64'(done), 64'(0));

      // flush mid-run
      launch(OP_MULTU, 32'h1357_9BDF, 32'h2468_ACE0, t0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'(0));
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      chk("flush_nodone", 64'(nd), 64'(0));
      chk("flush_hi", 64'(hi), 64'(mhi));
      chk("flush_lo", 64'(lo), 64'(mlo));

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: begin ra = 32'h8000_0000; rb = '1; end
            default: rb = $urandom;
         endcase
         do_op(ro, ra, rb, "rnd");
      end

      // reset mid-run after a divide-by-zero left state nonzero
      do_op(OP_DIVU, 32'hCAFE, 32'd0, "pre_rst");
      launch(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, t0);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("mrst_busy", 64'(busy), 64'(0));
      chk("mrst_done", 64'(done), 64'(0));
      chk("mrst_dz", 64'(div_by_zero), 64'(0));
      chk("mrst_hi", 64'(hi), 64'(0));
      chk("mrst_lo", 64'(lo), 64'(0));
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      chk("mrst_nodone", 64'(nd), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
